riscv_soft_imm_gen_stage: RTL and testbench

Registered, flow-controlled immediate-generation stage for the decode pipe. It is parametrised for RV32/RV64 datapath width and carries a sideband tag. It accepts an instruction word plus an immediate-type select and produces the sign- or zero-extended immediate one cycle later. A 2-entry skid buffer provides full throughput under backpressure. It adds CSR zimm and shift-amount types, plus an illegal-shamt flag, none of which the single-cycle combinational generator provides.

---
 rtl/riscv_soft_imm_gen_stage.sv | 153 +++++++++++++++
 tb/tb_riscv_soft_imm_gen_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/riscv_soft_imm_gen_stage.sv
// Registered immediate-generation stage with a 2-entry skid buffer.
// Decodes the immediate on input, then holds it in a main/skid register pair under backpressure.
module riscv_soft_imm_gen_stage #(
  parameter int XPR_LEN = 32,
  parameter int TAG_W   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        inst,
  input  logic [2:0]         imm_sel,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XPR_LEN-1:0] out_imm,
  output logic [TAG_W-1:0]   out_tag,
  output logic               shamt_err
);

  localparam logic [2:0] SEL_I     = 3'd0;
  localparam logic [2:0] SEL_S     = 3'd1;
  localparam logic [2:0] SEL_B     = 3'd2;
  localparam logic [2:0] SEL_U     = 3'd3;
  localparam logic [2:0] SEL_J     = 3'd4;
  localparam logic [2:0] SEL_Z     = 3'd5;
  localparam logic [2:0] SEL_SHAMT = 3'd6;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  function automatic logic [XPR_LEN-1:0] ext_imm(input logic [31:0] w, input logic [2:0] sel);
    logic signed [11:0] imm_i;
    logic signed [11:0] imm_s;
    logic signed [12:0] imm_b;
    logic signed [31:0] imm_u;
    logic signed [20:0] imm_j;
    logic [XPR_LEN-1:0] r;
    imm_i = $signed(w[31:20]);
    imm_s = $signed({w[31:25], w[11:7]});
    imm_b = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
    imm_u = $signed({w[31:12], 12'b0});
    imm_j = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
    r = '0;
    case (sel)
      SEL_I:     r = XPR_LEN'(imm_i);
      SEL_S:     r = XPR_LEN'(imm_s);
      SEL_B:     r = XPR_LEN'(imm_b);
      SEL_U:     r = XPR_LEN'(imm_u);
      SEL_J:     r = XPR_LEN'(imm_j);
      SEL_Z:     r = XPR_LEN'(w[19:15]);
      SEL_SHAMT: r = (XPR_LEN == 64) ? XPR_LEN'(w[25:20]) : XPR_LEN'(w[24:20]);
      default:   r = '0;
    endcase
    return r;
  endfunction

  function automatic logic shamt_bad(input logic [31:0] w, input logic [2:0] sel);
    return (sel == SEL_SHAMT) && (XPR_LEN == 32) && w[25];
  endfunction

  state_t state_q, state_d;
  logic   vld_p0, out_fire;
  logic   load_main, load_skid, main_from_skid;

  logic [XPR_LEN-1:0] imm_p0;
  logic               err_p0;
  logic [XPR_LEN-1:0] main_imm_p1, skid_imm_p1;
  logic [TAG_W-1:0]   main_tag_p1, skid_tag_p1;
  logic               main_err_p1, skid_err_p1;
  logic               unused_opcode;

  // Stage p0: decode on the input side
  assign unused_opcode = ^inst[6:0];
  assign imm_p0        = ext_imm(inst, imm_sel);
  assign err_p0        = shamt_bad(inst, imm_sel);

  // in_ready depends only on the state register, never on out_ready
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign vld_p0    = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (vld_p0) begin
          load_main = 1'b1;
          state_d   = ONE;
        end
      end
      ONE: begin
        if (vld_p0 && out_fire) begin
          load_main = 1'b1;
        end else if (out_fire) begin
          state_d = EMPTY;
        end else if (vld_p0) begin
          load_skid = 1'b1;
          state_d   = FULL;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_from_skid = 1'b1;
          state_d        = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Stage p1: main output register (cleared so outputs read zero after reset)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_imm_p1 <= '0;
      main_tag_p1 <= '0;
      main_err_p1 <= 1'b0;
    end else if (load_main) begin
      main_imm_p1 <= imm_p0;
      main_tag_p1 <= in_tag;
      main_err_p1 <= err_p0;
    end else if (main_from_skid) begin
      main_imm_p1 <= skid_imm_p1;
      main_tag_p1 <= skid_tag_p1;
      main_err_p1 <= skid_err_p1;
    end
  end

  // Skid data is only ever read while FULL, so it needs no reset
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_imm_p1 <= imm_p0;
      skid_tag_p1 <= in_tag;
      skid_err_p1 <= err_p0;
    end
  end

  assign out_imm   = main_imm_p1;
  assign out_tag   = main_tag_p1;
  assign shamt_err = main_err_p1;

endmodule

// File: tb/tb_riscv_soft_imm_gen_stage.sv
// Directed bench for riscv_soft_imm_gen_stage: RV32 and RV64 instances share one stimulus stream.
module tb_riscv_soft_imm_gen_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] inst;
  logic [2:0]  imm_sel;
  logic [7:0]  in_tag;
  logic        out_ready;

  logic        rdy32, vld32, err32;
  logic [31:0] imm32;
  logic [7:0]  tag32;
  logic        rdy64, vld64, err64;
  logic [63:0] imm64;
  logic [7:0]  tag64;

  int ncmp  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  riscv_soft_imm_gen_stage #(.XPR_LEN(32), .TAG_W(8)) u32 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy32),
    .inst(inst), .imm_sel(imm_sel), .in_tag(in_tag),
    .out_valid(vld32), .out_ready(out_ready), .out_imm(imm32),
    .out_tag(tag32), .shamt_err(err32)
  );

  riscv_soft_imm_gen_stage #(.XPR_LEN(64), .TAG_W(8)) u64 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy64),
    .inst(inst), .imm_sel(imm_sel), .in_tag(in_tag),
    .out_valid(vld64), .out_ready(out_ready), .out_imm(imm64),
    .out_tag(tag64), .shamt_err(err64)
  );

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] w;
    logic [31:0] e32;
    logic        e32_err;
    logic [63:0] e64;
    logic        e64_err;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] sel, input logic [31:0] w, input logic [7:0] tag);
    in_valid = 1'b1;
    imm_sel  = sel;
    inst     = w;
    in_tag   = tag;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{3'd0, 32'hFFF00093, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[1]  = '{3'd0, 32'h7FF00093, 32'h000007FF, 1'b0, 64'h00000000000007FF, 1'b0};
    vecs[2]  = '{3'd1, 32'hFE112E23, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[3]  = '{3'd2, 32'hFE000EE3, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[4]  = '{3'd3, 32'h800000B7, 32'h80000000, 1'b0, 64'hFFFFFFFF80000000, 1'b0};
    vecs[5]  = '{3'd3, 32'h123450B7, 32'h12345000, 1'b0, 64'h0000000012345000, 1'b0};
    vecs[6]  = '{3'd4, 32'hFFDFF06F, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[7]  = '{3'd5, 32'h000F8073, 32'h0000001F, 1'b0, 64'h000000000000001F, 1'b0};
    vecs[8]  = '{3'd5, 32'h80008073, 32'h00000001, 1'b0, 64'h0000000000000001, 1'b0};
    vecs[9]  = '{3'd6, 32'h02009093, 32'h00000000, 1'b1, 64'h0000000000000020, 1'b0};
    vecs[10] = '{3'd6, 32'h01F09093, 32'h0000001F, 1'b0, 64'h000000000000001F, 1'b0};
    vecs[11] = '{3'd7, 32'hFFFFFFFF, 32'h00000000, 1'b0, 64'h0000000000000000, 1'b0};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    inst      = 32'h0;
    imm_sel   = 3'd0;
    in_tag    = 8'h0;
    out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_vld32", vld32, 0);  chk("rst_vld64", vld64, 0);
    chk("rst_rdy32", rdy32, 1);  chk("rst_rdy64", rdy64, 1);
    chk("rst_imm32", imm32, 0);  chk("rst_imm64", imm64, 0);
    chk("rst_tag32", tag32, 0);  chk("rst_err32", err32, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single transfers through both widths
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].sel, vecs[i].w, 8'(8'h40 + i));
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("v%0d_vld32", i), vld32, 1);
      chk($sformatf("v%0d_vld64", i), vld64, 1);
      chk($sformatf("v%0d_imm32", i), imm32, vecs[i].e32);
      chk($sformatf("v%0d_err32", i), err32, vecs[i].e32_err);
      chk($sformatf("v%0d_imm64", i), imm64, vecs[i].e64);
      chk($sformatf("v%0d_err64", i), err64, vecs[i].e64_err);
      chk($sformatf("v%0d_tag32", i), tag32, 8'(8'h40 + i));
    end
    @(negedge clk);
    chk("drain_vld", vld32, 0);

    // Back-to-back B then J
    drive(3'd2, 32'hFE000EE3, 8'h21);
    @(negedge clk);
    chk("b2b_rdy", rdy32, 1);
    chk("b2b_imm_b", imm32, 32'hFFFFFFFC);
    chk("b2b_tag_b", tag32, 8'h21);
    drive(3'd4, 32'hFFDFF06F, 8'h22);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_vld_j", vld32, 1);
    chk("b2b_imm_j", imm32, 32'hFFFFFFFC);
    chk("b2b_tag_j", tag32, 8'h22);
    chk("b2b_rdy2", rdy32, 1);
    @(negedge clk);
    chk("b2b_drain", vld32, 0);

    // Stall: fill both entries, third offer held upstream
    out_ready = 1'b0;
    drive(3'd0, 32'h00100093, 8'd1);
    @(negedge clk);
    chk("st_rdy1", rdy32, 1);
    chk("st_tag1", tag32, 8'd1);
    drive(3'd0, 32'h00200093, 8'd2);
    @(negedge clk);
    chk("st_rdy_full", rdy32, 0);
    chk("st_rdy_full64", rdy64, 0);
    chk("st_hold_tag_a", tag32, 8'd1);
    drive(3'd0, 32'h00300093, 8'd3);
    @(negedge clk);
    chk("st_rdy_full2", rdy32, 0);
    chk("st_hold_tag_b", tag32, 8'd1);
    chk("st_hold_imm", imm32, 32'd1);
    chk("st_hold_vld", vld32, 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("fl_vld2", vld32, 1);
    chk("fl_tag2", tag32, 8'd2);
    chk("fl_imm2", imm32, 32'd2);
    chk("fl_rdy", rdy32, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("fl_vld3", vld32, 1);
    chk("fl_tag3", tag32, 8'd3);
    chk("fl_imm3", imm64, 64'd3);
    @(negedge clk);
    chk("fl_drain", vld32, 0);

    // Asynchronous reset while FULL
    out_ready = 1'b0;
    drive(3'd0, 32'h00A00093, 8'h0A);
    @(negedge clk);
    drive(3'd0, 32'h00B00093, 8'h0B);
    @(negedge clk);
    in_valid = 1'b0;
    chk("ar_full", rdy32, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_vld32", vld32, 0);
    chk("ar_vld64", vld64, 0);
    chk("ar_rdy32", rdy32, 1);
    chk("ar_tag", tag32, 0);
    chk("ar_imm", imm64, 0);
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("ar_idle", vld32, 0);
    drive(3'd5, 32'h000F8073, 8'h0C);
    @(negedge clk);
    in_valid = 1'b0;
    chk("ar_new_vld", vld32, 1);
    chk("ar_new_tag", tag32, 8'h0C);
    chk("ar_new_imm", imm32, 32'h1F);
    @(negedge clk);
    chk("ar_no_stale", vld32, 0);
    chk("ar_no_stale64", vld64, 0);
    @(negedge clk);
    chk("ar_no_stale2", vld32, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
